// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha_pkg
//  Description : Shared constants and state type for the SHA-256 chaining-value
//                register bank (word width, initial hash value, FSM states).
//  Revision    : 1.0  initial release
// ============================================================================
package sha_pkg;

    // Bits per SHA-256 hash word
    localparam int WORD_W = 32;

    // SHA-256 initial hash value, H0 in the MSBs down to H7 in the LSBs
    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // Message-level controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : sha_pkg
`default_nettype wire

// File: rtl/sha_word_acc.sv
`default_nettype none
// ============================================================================
//  Module      : sha_word_acc
//  Description : One chaining-value word. Loads its IV word on reset or message
//                start, adds the incoming working variable modulo 2^WIDTH on an
//                accepted beat, otherwise holds.
//  Revision    : 1.0  initial release
// ============================================================================
module sha_word_acc #(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              add,
    input  logic [WIDTH-1:0]  addend,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  sum
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_sum;

    // Carry out of the word is discarded: each word wraps independently
    assign w_sum = r_q + addend;
    assign q     = r_q;
    assign sum   = w_sum;

    // Reset and load both restore the IV word; load wins over add
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_q <= INIT;
        end else if (add) begin
            r_q <= w_sum;
        end
    end

endmodule : sha_word_acc
`default_nettype wire

// File: rtl/sha256_hash_state.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_hash_state
//  Description : SHA-256 chaining-value register bank. Loads the IV at message
//                start, accumulates one compression result per block, counts
//                blocks and hands the final digest out under valid/ack.
//  Revision    : 1.0  initial release
// ============================================================================
module sha256_hash_state
    import sha_pkg::*;
#(
    parameter int                         WIDTH      = WORD_W,
    parameter int                         NWORDS     = 8,
    parameter int                         MAX_BLOCKS = 16,
    parameter logic [NWORDS*WIDTH-1:0]    IV         = SHA256_IV,
    localparam int                        CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_blocks,
    input  logic                       wv_valid,
    input  logic [NWORDS*WIDTH-1:0]    wv_in,
    output logic                       wv_ready,
    output logic [NWORDS*WIDTH-1:0]    h_cur,
    output logic [CNT_W-1:0]           blk_cnt,
    output logic                       busy,
    output logic                       digest_valid,
    output logic [NWORDS*WIDTH-1:0]    digest,
    input  logic                       digest_ack,
    output logic                       err
);

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           r_target;
    logic [NWORDS*WIDTH-1:0]    r_digest;
    logic                       r_digest_valid;
    logic                       r_err;

    logic                       w_accept;
    logic [CNT_W-1:0]           w_cnt_inc;
    logic [NWORDS*WIDTH-1:0]    w_sum;

    // start preempts any beat arriving in the same cycle
    assign w_accept  = wv_valid && !start && (r_state == ACCUM);
    assign w_cnt_inc = r_cnt + 1'b1;

    // One accumulator per hash word; slice offsets keep H0 in the MSBs
    for (genvar g = 0; g < NWORDS; g++) begin : g_word
        sha_word_acc #(
            .WIDTH (WIDTH),
            .INIT  (IV[g*WIDTH +: WIDTH])
        ) u_word (
            .clk    (clk),
            .rst    (rst),
            .load   (start),
            .add    (w_accept),
            .addend (wv_in[g*WIDTH +: WIDTH]),
            .q      (h_cur[g*WIDTH +: WIDTH]),
            .sum    (w_sum[g*WIDTH +: WIDTH])
        );
    end

    // Message controller: block counting, digest capture and stray-beat flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_target       <= CNT_W'(1);
            r_digest       <= '0;
            r_digest_valid <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            // A beat outside ACCUM is flagged, unless start swallows it
            r_err <= wv_valid && !start && (r_state != ACCUM);
            if (start) begin
                r_state        <= ACCUM;
                r_cnt          <= '0;
                r_target       <= (num_blocks == '0) ? CNT_W'(1) : num_blocks;
                r_digest_valid <= 1'b0;
            end else begin
                case (r_state)
                    ACCUM: begin
                        // Saturating count; the final beat publishes the sum
                        if (w_accept && (r_cnt != r_target)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == r_target) begin
                                r_digest       <= w_sum;
                                r_digest_valid <= 1'b1;
                                r_state        <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (digest_ack) begin
                            r_digest_valid <= 1'b0;
                            r_state        <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wv_ready     = (r_state == ACCUM);
    assign busy         = (r_state == ACCUM);
    assign blk_cnt      = r_cnt;
    assign digest       = r_digest;
    assign digest_valid = r_digest_valid;
    assign err          = r_err;

endmodule : sha256_hash_state
`default_nettype wire
